gate_unit_arbiter: RTL and testbench
====================================

# gate_unit_arbiter

Shares one registered bitwise logic unit (NAND, AND, OR, NOT, NOR, XOR) among `N_REQ` requesters. Uses round-robin arbitration and per-requester valid/ready handshakes. Produces a single-entry response stream tagged with the requester index. It sits between the gate-level primitives and any block that needs logic operations without owning its own gate array.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, minimum 2.
- `WIDTH`, default 8: operand and result width in bits.
- `ID_W`, default 2: width of the requester tag; must be at least `$clog2(N_REQ)`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `req_valid` input `N_REQ`: bit i means requester i presents an operation.
- `req_ready` output `N_REQ`: bit i means requester i's operation is accepted this cycle; one-hot or zero.
- `req_op` input `3*N_REQ`: opcode of requester i in bits `[3i+2:3i]`.
- `req_a` input `WIDTH*N_REQ`: operand A of requester i in slice i.
- `req_b` input `WIDTH*N_REQ`: operand B of requester i in slice i.
- `rsp_valid` output 1: the response register holds a result.
- `rsp_ready` input 1: the consumer takes the response this cycle.
- `rsp_data` output `WIDTH`: the result.
- `rsp_id` output `ID_W`: index of the requester that owns the result.
- `rsp_err` output 1: the opcode was illegal.

## Operation
- Opcodes:
  - 0 = NAND: ~(a&b)
  - 1 = AND: a&b
  - 2 = OR: a|b
  - 3 = NOT: ~a, b ignored
  - 4 = NOR: ~(a|b)
  - 5 = XOR: a^b
  - 6 and 7 are illegal: `rsp_data` = 0 and `rsp_err` = 1.
- Results are bitwise across all `WIDTH` bits, with no carries or width growth.
- Two states:
  - EMPTY (`rsp_valid`=0).
  - FULL (`rsp_valid`=1).
- Accept condition: `can_accept` = EMPTY, or (FULL and `rsp_ready`).
- Arbitration:
  - A round-robin pointer `ptr` names the highest-priority requester.
  - Search order is `ptr`, `ptr+1`, … modulo `N_REQ`.
  - The first requester with `req_valid` set wins.
- `req_ready[w]` = `can_accept` and w is the winner. It is combinational from `req_valid`, `rsp_ready` and the state. All other bits are 0.
- On acceptance:
  - The response register loads the result, `rsp_id`=w and `rsp_err`.
  - The state goes to FULL and `ptr` becomes (w+1) mod `N_REQ`.
- FULL with `rsp_ready`=1 and no winner: the state goes to EMPTY. `rsp_data`, `rsp_id` and `rsp_err` hold their last values.
- `ptr` changes only on acceptance. It never moves during backpressure or idle cycles.
- Requesters hold `req_valid`, `req_op`, `req_a` and `req_b` stable until `req_ready`. The block does not require this for correctness, but does not promise fairness if it is violated.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_err`=0.
  - `ptr`=0.
  - `req_ready` = all 0 during the `rst` cycle.
- Latency: a request accepted at edge t gives `rsp_valid`=1 with its result after edge t, i.e. visible in cycle t+1.
- Throughput: one operation per cycle while `rsp_ready`=1 (drain and load happen at the same edge).
- Backpressure (FULL, `rsp_ready`=0):
  - All `req_ready` are 0.
  - `rsp_*` stay stable until the consumer takes the response.
- Simultaneous drain and accept: the new result replaces the old one at the same edge, and `rsp_valid` stays 1.
- Reset mid-operation: `rst` in any state drops a held response and clears `ptr` at that edge. No request is accepted during the reset cycle.
- Boundary cases:
  - `ptr` wraps from `N_REQ`-1 to 0.
  - A single continuous requester is granted every cycle regardless of `ptr`.

## Test plan
- Opcode sweep on requester 0, with a=F0 and b=CC, ops 0–5 back to back and `rsp_ready`=1:
  - `rsp_data` = 3F, C0, FC, 0F, 03, 3C, one per cycle, each one cycle after its acceptance.
  - `rsp_id`=0 and `rsp_err`=0 throughout.
- Illegal opcodes: op=6, then op=7, with any operands → `rsp_data`=00 and `rsp_err`=1 for each. `ptr` still advances.
- Contention: all 4 `req_valid` held high and `rsp_ready`=1 for 8 cycles → grants and `rsp_id` follow 0,1,2,3,0,1,2,3. Exactly one `req_ready` bit is high per cycle.
- Backpressure: FULL with `rsp_id`=1, `rsp_ready`=0 for 5 cycles with requesters 2 and 3 pending:
  - `rsp_*` are unchanged and `req_ready`=0.
  - After `rsp_ready` rises, requester 2 is granted at that edge and then requester 3.
- Pointer fairness: only requester 2 is granted first, then requesters 1 and 3 raise valid together → requester 3 is granted before requester 1.
- Reset mid-operation: assert `rst` for 1 cycle while FULL and `ptr`=2:
  - Next cycle `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_err`=0.
  - With all requesters valid, the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit among N_REQ requesters.
// A single response register is held until the consumer takes it.

module gate_alu #(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] data,
    output logic             err
);
    always_comb begin
        data = '0;
        err  = 1'b0;
        case (op)
            3'd0:    data = ~(a & b);
            3'd1:    data = a & b;
            3'd2:    data = a | b;
            3'd3:    data = ~a;
            3'd4:    data = ~(a | b);
            3'd5:    data = a ^ b;
            default: err  = 1'b1;
        endcase
    end
endmodule

module gate_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [3*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_err
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state, state_nx;
    logic [ID_W-1:0] ptr, ptr_nx, win;
    logic            found, can_accept, load;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b, alu_data;
    logic             alu_err;

    // First valid requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    assign can_accept = !rst && (state == EMPTY || rsp_ready);
    assign load       = can_accept && found;

    always_comb begin
        req_ready = '0;
        if (load) req_ready[win] = 1'b1;
    end

    assign sel_op = req_op[3*int'(win) +: 3];
    assign sel_a  = req_a[WIDTH*int'(win) +: WIDTH];
    assign sel_b  = req_b[WIDTH*int'(win) +: WIDTH];

    gate_alu #(.WIDTH(WIDTH)) u_alu (
        .op   (sel_op),
        .a    (sel_a),
        .b    (sel_b),
        .data (alu_data),
        .err  (alu_err)
    );

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        if (load) begin
            state_nx = FULL;
            ptr_nx   = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
        end else if (state == FULL && rsp_ready) begin
            state_nx = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            ptr      <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            // Payload holds its last value when draining without a new grant.
            if (load) begin
                rsp_data <= alu_data;
                rsp_id   <= win;
                rsp_err  <= alu_err;
            end
        end
    end

    assign rsp_valid = (state == FULL);
endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_gate_unit_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready;
    logic [3*N-1:0] req_op;
    logic [W*N-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready;
    logic [W-1:0]   rsp_data;
    logic [IW-1:0]  rsp_id;
    logic           rsp_err;

    int checks = 0;
    int errors = 0;

    // model state
    int           m_ptr;
    bit           m_full;
    logic [W-1:0] m_data;
    int           m_id;
    bit           m_err;

    gate_unit_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int i, input bit v, input int op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2:0] o;
        o = op[2:0];
        req_valid[i]      = v;
        req_op[3*i +: 3]  = o;
        req_a[W*i +: W]   = a;
        req_b[W*i +: W]   = b;
    endtask

    function automatic logic [W:0] ref_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            0: return {1'b0, ~(a & b)};
            1: return {1'b0, a & b};
            2: return {1'b0, a | b};
            3: return {1'b0, ~a};
            4: return {1'b0, ~(a | b)};
            5: return {1'b0, a ^ b};
            default: return {1'b1, {W{1'b0}}};
        endcase
    endfunction

    function automatic int m_winner();
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int w;
        w = m_winner();
        if (!rst && (!m_full || rsp_ready) && w >= 0) return N'(1) << w;
        return '0;
    endfunction

    task automatic m_edge();
        int w;
        logic [W:0] r;
        w = m_winner();
        if (rst) begin
            m_ptr = 0; m_full = 0; m_data = '0; m_id = 0; m_err = 0;
        end else if ((!m_full || rsp_ready) && w >= 0) begin
            r = ref_op(int'(req_op[3*w +: 3]), req_a[W*w +: W], req_b[W*w +: W]);
            m_full = 1; m_data = r[W-1:0]; m_err = r[W]; m_id = w;
            m_ptr = (w + 1) % N;
        end else if (m_full && rsp_ready) begin
            m_full = 0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; rsp_ready = 1; req_valid = '1;
        #1; checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== '0) begin
            errors++; $display("FAIL reset_rsp got v=%b d=%h id=%0d e=%b exp zeros", rsp_valid, rsp_data, rsp_id, rsp_err);
        end
        @(negedge clk); rst = 0; req_valid = '0;
    endtask

    task automatic test_opcodes();
        logic [W-1:0] exp_d [6] = '{8'h3F, 8'hC0, 8'hFC, 8'h0F, 8'h03, 8'h3C};
        rsp_ready = 1;
        for (int op = 0; op < 6; op++) begin
            @(negedge clk);
            req_valid = '0; set_req(0, 1, op, 8'hF0, 8'hCC);
            #1; checks++;
            if (req_ready !== 4'b0001) begin errors++; $display("FAIL opcode_ready op=%0d got=%b exp=0001", op, req_ready); end
            @(posedge clk); #1; checks++;
            if (!(rsp_valid === 1'b1 && rsp_data === exp_d[op] && rsp_id === 2'd0 && rsp_err === 1'b0)) begin
                errors++; $display("FAIL opcode op=%0d got v=%b d=%h id=%0d e=%b exp d=%h", op, rsp_valid, rsp_data, rsp_id, rsp_err, exp_d[op]);
            end
        end
    endtask

    task automatic test_illegal();
        for (int op = 6; op < 8; op++) begin
            @(negedge clk);
            req_valid = '0; set_req(0, 1, op, W'($urandom), W'($urandom));
            @(posedge clk); #1; checks++;
            if (!(rsp_valid === 1'b1 && rsp_data === 8'h00 && rsp_err === 1'b1 && rsp_id === 2'd0)) begin
                errors++; $display("FAIL illegal op=%0d got d=%h e=%b id=%0d exp d=00 e=1", op, rsp_data, rsp_err, rsp_id);
            end
        end
        // ptr advanced past requester 0, so requester 1 wins a tie with it
        @(negedge clk);
        set_req(0, 1, 1, 8'hFF, 8'hFF); set_req(1, 1, 1, 8'hFF, 8'hFF);
        #1; checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL illegal_ptr got=%b exp=0010", req_ready); end
        @(posedge clk); #1;
        @(negedge clk); req_valid = '0;
    endtask

    task automatic test_contention();
        @(negedge clk); rst = 1; req_valid = '0;
        @(negedge clk); rst = 0; rsp_ready = 1;
        for (int i = 0; i < N; i++) set_req(i, 1, 2, W'(i), 8'h10);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1; checks++;
            if (req_ready !== 4'(1 << (c % 4))) begin errors++; $display("FAIL contention_ready c=%0d got=%b exp=%b", c, req_ready, 4'(1 << (c % 4))); end
            @(posedge clk); #1; checks++;
            if (!(rsp_id === 2'(c % 4) && rsp_data === (8'h10 | 8'(c % 4)))) begin
                errors++; $display("FAIL contention_id c=%0d got id=%0d d=%h exp id=%0d", c, rsp_id, rsp_data, c % 4);
            end
        end
        @(negedge clk); req_valid = '0;
    endtask

    task automatic test_backpressure();
        // ptr is 0 here; grant requester 1 alone to get FULL with id 1
        set_req(1, 1, 1, 8'hAA, 8'h0F); rsp_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        req_valid = '0; rsp_ready = 0;
        set_req(2, 1, 5, 8'hFF, 8'h01); set_req(3, 1, 3, 8'h55, 8'h00);
        for (int c = 0; c < 5; c++) begin
            #1; checks++;
            if (!(req_ready === 4'b0000 && rsp_valid === 1'b1 && rsp_id === 2'd1 && rsp_data === 8'h0A && rsp_err === 1'b0)) begin
                errors++; $display("FAIL backpressure c=%0d rdy=%b v=%b id=%0d d=%h exp rdy=0000 id=1 d=0a", c, req_ready, rsp_valid, rsp_id, rsp_data);
            end
            @(negedge clk);
        end
        rsp_ready = 1;
        #1; checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release got=%b exp=0100", req_ready); end
        @(posedge clk); #1; checks++;
        if (!(rsp_id === 2'd2 && rsp_data === 8'hFE)) begin errors++; $display("FAIL bp_rsp2 id=%0d d=%h exp id=2 d=fe", rsp_id, rsp_data); end
        @(negedge clk); req_valid[2] = 0;
        #1; checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_next got=%b exp=1000", req_ready); end
        @(posedge clk); #1; checks++;
        if (!(rsp_id === 2'd3 && rsp_data === 8'hAA)) begin errors++; $display("FAIL bp_rsp3 id=%0d d=%h exp id=3 d=aa", rsp_id, rsp_data); end
        @(negedge clk); req_valid = '0;
        @(posedge clk); #1; checks++;
        if (!(rsp_valid === 1'b0 && rsp_id === 2'd3 && rsp_data === 8'hAA)) begin
            errors++; $display("FAIL drain v=%b id=%0d d=%h exp v=0 id=3 d=aa", rsp_valid, rsp_id, rsp_data);
        end
    endtask

    task automatic test_fairness();
        @(negedge clk);
        set_req(2, 1, 1, 8'h0F, 8'hFF);
        #1; checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL fair_first got=%b exp=0100", req_ready); end
        @(negedge clk);
        req_valid = '0; set_req(1, 1, 1, 8'h11, 8'hFF); set_req(3, 1, 1, 8'h33, 8'hFF);
        #1; checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL fair_tie got=%b exp=1000", req_ready); end
        @(negedge clk); req_valid[3] = 0;
        #1; checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL fair_second got=%b exp=0010", req_ready); end
        @(posedge clk); #1; checks++;
        if (!(rsp_id === 2'd1 && rsp_data === 8'h11)) begin errors++; $display("FAIL fair_rsp id=%0d d=%h exp id=1 d=11", rsp_id, rsp_data); end
    endtask

    task automatic test_reset_mid();
        // FULL with ptr=2 from the previous grant of requester 1
        @(negedge clk);
        rsp_ready = 0; rst = 1; req_valid = '1;
        #1; checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL rstmid_ready got=%b exp=0000", req_ready); end
        @(posedge clk); #1; checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== '0) begin
            errors++; $display("FAIL rstmid_rsp v=%b d=%h id=%0d e=%b exp zeros", rsp_valid, rsp_data, rsp_id, rsp_err);
        end
        @(negedge clk); rst = 0; rsp_ready = 1;
        #1; checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_grant got=%b exp=0001", req_ready); end
        @(posedge clk); #1;
        @(negedge clk); req_valid = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] exp_r;
        @(negedge clk); rst = 1; m_edge(); @(posedge clk); #1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 49) == 0);
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++)
                set_req(i, ($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)), W'($urandom), W'($urandom));
            #1; exp_r = m_ready(); checks++;
            if (req_ready !== exp_r) begin errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_r); end
            m_edge();
            @(posedge clk); #1; checks++;
            if (!(rsp_valid === m_full && rsp_data === m_data && rsp_id === IW'(m_id) && rsp_err === m_err)) begin
                errors++; $display("FAIL rand_rsp c=%0d got v=%b d=%h id=%0d e=%b exp v=%b d=%h id=%0d e=%b",
                                   c, rsp_valid, rsp_data, rsp_id, rsp_err, m_full, m_data, m_id, m_err);
            end
        end
        @(negedge clk); rst = 0; req_valid = '0;
    endtask

    initial begin
        rst = 1; rsp_ready = 0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        test_reset();
        test_opcodes();
        test_illegal();
        test_contention();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
